mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, ACCESS-state cycles without mem_ready before abort (MEM_TIMEOUT_EN builds only).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch read request; held until if_ack.
REQ-005 if_addr  input  32  fetch address; stable while if_req high.
REQ-006 if_ack  output  1  one-cycle fetch completion pulse.
REQ-007 dm_req  input  1  data request; held until dm_ack.
REQ-008 dm_we  input  1  1 = data write, 0 = data read.
REQ-009 dm_addr  input  32  data address; stable while dm_req high.
REQ-010 dm_ack  output  1  one-cycle data completion pulse.
REQ-011 mar_write  output  1  load strobe to the memory address register.
REQ-012 mar_addr  output  32  address presented to the memory address register.
REQ-013 mem_rd / mem_wr  output  1 each  memory read/write strobes; never both high.
REQ-014 mem_ready  input  1  memory completion, sampled only in ACCESS.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 grant_id  output  1  current/last owner: 0 = fetch, 1 = data.
REQ-017 err  output  1  timeout flag, pulses with the ack.

Function
REQ-018 States IDLE, ADDR, ACCESS, DONE; encoding from the shared package.
REQ-019 IDLE: any request -> arbitrate, capture winner's address and dm_we in registers, go ADDR; otherwise stay.
REQ-020 Arbitration round-robin: single requester wins; both requesting -> the one not granted last; after reset fetch wins first tie.
REQ-021 ADDR: mar_write=1 for exactly one cycle, mar_addr = captured address; go ACCESS next cycle unconditionally.
REQ-022 ACCESS: mem_rd=1 (fetch, or data with dm_we=0) or mem_wr=1 (data with dm_we=1) every cycle; mem_ready=1 -> DONE.
REQ-023 DONE: ack of granted requester high exactly one cycle; strobes low; go IDLE.
REQ-024 Minimum latency: request sampled in IDLE at cycle N -> ack high in cycle N+3 when mem_ready is high on the first ACCESS cycle.
REQ-025 Requests arriving or dropping outside IDLE are not sampled; an accepted access always completes and acks even if its req dropped.
REQ-026 Back-to-back: requester still high in IDLE after DONE is re-arbitrated normally; no idle cycle beyond IDLE is inserted.
REQ-027 mar_addr holds the last captured address outside ADDR; mar_write low outside ADDR.

Reset
REQ-028 reset asserted -> IDLE immediately; all outputs 0 (mar_addr 32'h0, grant_id 0, err 0), round-robin pointer favours fetch, timeout counter 0.
REQ-029 Reset mid-access aborts without ack; first post-reset request is handled as fresh.

Configuration
REQ-030 Macro MEM_TIMEOUT_EN: defined -> ACCESS counter increments each cycle without mem_ready; on reaching TIMEOUT_CYC go DONE with err=1 together with the ack; counter clears on entry to ACCESS.
REQ-031 MEM_TIMEOUT_EN undefined -> ACCESS waits indefinitely, no counter logic, err tied 0.

Structure
REQ-032 Package mem_ctrl_pkg holds the state enum, requester ID constants (REQ_FETCH=0, REQ_DATA=1) and the 32-bit address width constant.
REQ-033 Sub-module rr_arbiter2: two request inputs, last-grant register, one-hot grant output, advanced only on IDLE->ADDR.

Verification
REQ-034 Fetch only, if_addr=32'h0000_0100, mem_ready high first ACCESS cycle -> mar_write one cycle with mar_addr=32'h100, mem_rd one cycle, if_ack at cycle N+3, dm_ack 0.
REQ-035 Both request simultaneously from reset, dm_addr=32'h2000, if_addr=32'h40 -> fetch served first, then data, grant_id 0 then 1.
REQ-036 Data write dm_we=1, dm_addr=32'h80, mem_ready after 5 ACCESS cycles -> mem_wr high 5 cycles, mem_rd never high, single dm_ack pulse.
REQ-037 MEM_TIMEOUT_EN, TIMEOUT_CYC=4, mem_ready held 0 -> after 4 ACCESS cycles if_ack and err pulse together, FSM returns to IDLE.
REQ-038 reset asserted during ACCESS -> outputs 0 same cycle, no ack, next request from IDLE with fetch priority.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
package mem_ctrl_pkg;

  localparam int ADDR_W = 32;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // The access captured at arbitration time; it lives until the next grant.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              id;
  } req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; bit 0 = fetch, bit 1 = data.
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_q == REQ_DATA) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Resetting to "data last" makes fetch win the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_q <= REQ_DATA;
    else if (advance && (|grant))
      last_q <= grant[1];
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Fetch/data memory access sequencer: IDLE -> ADDR -> ACCESS -> DONE.
// Optional MEM_TIMEOUT_EN aborts a stalled ACCESS after TIMEOUT_CYC cycles and flags err.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYC = 16
)
`endif
(
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  output logic              dm_ack,
  output logic              mar_write,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic              busy,
  output logic              grant_id,
  output logic              err
);

  state_e     state_q, state_d;
  req_t       cur_q;
  logic [1:0] grant;
  logic       accept;
  logic       to_hit;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({dm_req, if_req}),
    .advance (state_q == ST_IDLE),
    .grant   (grant)
  );

  assign accept = (state_q == ST_IDLE) && (|grant);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt_q;
  logic             err_q;

  assign to_hit = (state_q == ST_ACCESS) && !mem_ready &&
                  (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // err_q is latched on the way out of ACCESS and shown only in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ST_ADDR)
        to_cnt_q <= '0;
      else if (state_q == ST_ACCESS && !mem_ready)
        to_cnt_q <= to_cnt_q + 1'b1;
      if (state_q == ST_ACCESS)
        err_q <= to_hit;
    end
  end

  assign err = (state_q == ST_DONE) && err_q;
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (|grant) state_d = ST_ADDR;
      ST_ADDR:   state_d = ST_ACCESS;
      ST_ACCESS: if (mem_ready || to_hit) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Captured request; its address doubles as the held mar_addr value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q <= '0;
    end else if (accept) begin
      cur_q.addr <= grant[1] ? dm_addr : if_addr;
      cur_q.we   <= grant[1] & dm_we;
      cur_q.id   <= grant[1];
    end
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    mar_write = (state_q == ST_ADDR);
    mem_rd    = (state_q == ST_ACCESS) && !cur_q.we;
    mem_wr    = (state_q == ST_ACCESS) &&  cur_q.we;
    if_ack    = (state_q == ST_DONE) && (cur_q.id == REQ_FETCH);
    dm_ack    = (state_q == ST_DONE) && (cur_q.id == REQ_DATA);
  end

  assign mar_addr = cur_q.addr;
  assign grant_id = cur_q.id;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-timeline reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0;
  logic        if_ack, dm_ack, mar_write, mem_rd, mem_wr, busy, grant_id, err;
  logic [31:0] mar_addr;
  logic [7:0]  ctl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign ctl = {busy, mar_write, mem_rd, mem_wr, if_ack, dm_ack, grant_id, err};

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
  mem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_ack(dm_ack),
    .mar_write(mar_write), .mar_addr(mar_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ready(mem_ready), .busy(busy), .grant_id(grant_id), .err(err)
  );
`else
  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_ack(dm_ack),
    .mar_write(mar_write), .mar_addr(mar_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ready(mem_ready), .busy(busy), .grant_id(grant_id), .err(err)
  );
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
    end
  endtask

  // Raise or drop a requester; address/we are re-rolled whenever the line changes.
  task automatic set_req(input int r, input bit on);
    if (r == 0) begin
      if_req  = on;
      if_addr = $urandom;
    end else begin
      dm_req  = on;
      dm_addr = $urandom;
      dm_we   = 1'($urandom);
    end
  endtask

  initial begin
    // Model: one in-flight access described by its accept cycle and phase lengths.
    bit          act, own, m_we, m_err, last, gid, rel, rst_done, just_done, rq;
    bit          e_busy, e_mw, e_rd, e_wr, e_ia, e_da, e_err;
    int          a, k, alen, dd, txn, d;
    logic [31:0] mar, exp_mar;
    logic [7:0]  exp_ctl;

    act = 0; own = 0; m_we = 0; m_err = 0; last = 1; gid = 0;
    rel = 1; rst_done = 0; a = 0; k = 0; alen = 0; dd = 0; txn = 0; mar = '0;

    #2;
    chk("rst_ctl", 64'(ctl), 64'h0);
    chk("rst_mar", 64'(mar_addr), 64'h0);

    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      just_done = 0;
      if (rel) begin
        // Fresh start after reset: both sides request, fetch must win.
        reset = 1'b0; rel = 0; act = 0; last = 1; gid = 0; mar = '0;
        set_req(0, 1'b1);
        set_req(1, 1'b1);
        if (cyc == 0) begin
          if_addr = 32'h40;
          dm_addr = 32'h2000;
          dm_we   = 1'b1;
        end
      end else begin
        if (act && cyc > a + dd) begin
          act = 0;
          just_done = 1;
        end
        for (int r = 0; r < 2; r++) begin
          rq = (r == 0) ? if_req : dm_req;
          if ((act || just_done) && r == int'(own)) begin
            if (rq && ($urandom % (act ? 8 : 2)) == 0) set_req(r, 1'b0);
            else if (rq && just_done && ($urandom % 2) == 0) set_req(r, 1'b1);
          end else if (!rq && ($urandom % 3) == 0) begin
            set_req(r, 1'b1);
          end
        end
      end

      e_busy = 0; e_mw = 0; e_rd = 0; e_wr = 0; e_ia = 0; e_da = 0; e_err = 0;
      mem_ready = 1'($urandom);
      if (act) begin
        d = cyc - a;
        e_busy = 1;
        if (d == 1) begin
          e_mw = 1;
        end else if (d < dd) begin
          e_rd = !m_we;
          e_wr = m_we;
          mem_ready = (d - 2 == k);
        end else begin
          e_ia  = !own;
          e_da  = own;
          e_err = m_err;
        end
      end
      exp_ctl = {e_busy, e_mw, e_rd, e_wr, e_ia, e_da, gid, e_err};
      exp_mar = mar;

      if (!act && (if_req || dm_req)) begin
        own  = (if_req && dm_req) ? !last : dm_req;
        last = own;
        act  = 1;
        a    = cyc;
        m_we = own & dm_we;
        mar  = own ? dm_addr : if_addr;
        gid  = own;
        k    = (txn == 0) ? 0 : (txn == 1) ? 5 : int'($urandom_range(0, 6));
        txn++;
        alen  = k + 1;
        m_err = 0;
`ifdef MEM_TIMEOUT_EN
        if (k >= TO) begin
          alen  = TO;
          m_err = 1;
        end
`endif
        dd = 2 + alen;
      end

      @(negedge clk);
      chk("ctl", 64'(ctl), 64'(exp_ctl));
      chk("mar_addr", 64'(mar_addr), 64'(exp_mar));

      // One asynchronous reset in the middle of an ACCESS phase.
      if (!rst_done && cyc >= 700 && act && (cyc - a) >= 2 && (cyc - a) < dd) begin
        reset = 1'b1;
        #1;
        chk("midrst_ctl", 64'(ctl), 64'h0);
        chk("midrst_mar", 64'(mar_addr), 64'h0);
        rel = 1;
        rst_done = 1;
      end
    end

    chk("midrst_seen", 64'(rst_done), 64'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
